// File: rtl/sub_pkg.sv
// Shared widths, the signed difference type, and the subtractor-output conversion
// used by sub_result_fifo.
package sub_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DIFF_W = 5;

  typedef logic signed [DIFF_W-1:0] sub_diff_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_t;

  // final_carry = 0 means the subtraction borrowed, so the sign bit is its inverse.
  function automatic sub_diff_t to_diff(input logic [NIB_W-1:0] s, input logic final_carry);
    return sub_diff_t'({~final_carry, s});
  endfunction

endpackage

// File: rtl/sub_result_fifo_if.sv
// Valid/ready bundle between subtractor_4bit, sub_result_fifo and its consumer.
// The slave modport is the FIFO's view; master is the surrounding environment.
interface sub_result_fifo_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
);
  import sub_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [NIB_W-1:0]         s;
  logic                     final_carry;
  logic                     out_valid;
  logic                     out_ready;
  sub_diff_t                out_diff;
  logic                     out_neg;
  logic [$clog2(DEPTH):0]   count;
  logic [CNT_W-1:0]         borrow_cnt;

  modport master (
    output in_valid, s, final_carry, out_ready,
    input  in_ready, out_valid, out_diff, out_neg, count, borrow_cnt
  );

  modport slave (
    input  in_valid, s, final_carry, out_ready,
    output in_ready, out_valid, out_diff, out_neg, count, borrow_cnt
  );

endinterface

// File: rtl/sub_fifo_ram.sv
// DEPTH x DIFF_W storage for sub_result_fifo: one synchronous write port,
// one asynchronous read port.
module sub_fifo_ram
  import sub_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  sub_diff_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output sub_diff_t                rdata
);

  sub_diff_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sub_result_fifo.sv
// Valid/ready FIFO buffering 4-bit subtractor results as 5-bit signed differences.
// Define SUB_FIFO_STATS_EN to build the saturating borrow counter.
module sub_result_fifo
  import sub_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  sub_result_fifo_if.slave   bus
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] count_q, count_nxt;
  occ_state_t          occ;
  logic                in_rdy, out_vld, push, pop;
  sub_diff_t           head, diff_out;

  assign push = bus.in_valid & in_rdy;
  assign pop  = bus.out_ready & out_vld;

  // State register: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
    end
  end

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0)          occ = OCC_EMPTY;
    else if (count_q == FULL_CNT) occ = OCC_FULL;
  end

  // Next-state: occupancy count transitions
  always_comb begin
    count_nxt = count_q;
    unique case (occ)
      OCC_EMPTY:   if (push) count_nxt = count_q + 1'b1;
      OCC_PARTIAL: begin
        if (push && !pop)      count_nxt = count_q + 1'b1;
        else if (pop && !push) count_nxt = count_q - 1'b1;
      end
      OCC_FULL:    if (pop) count_nxt = count_q - 1'b1;
      default:     count_nxt = count_q;
    endcase
  end

  // Outputs: head is gated so out_diff is defined before storage is ever written.
  always_comb begin
    in_rdy   = (occ != OCC_FULL);
    out_vld  = (occ != OCC_EMPTY);
    diff_out = out_vld ? head : '0;
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_diff  = diff_out;
  assign bus.out_neg   = diff_out[DIFF_W-1];
  assign bus.count     = count_q;

  sub_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (to_diff(bus.s, bus.final_carry)),
    .raddr (rd_ptr),
    .rdata (head)
  );

`ifdef SUB_FIFO_STATS_EN
  logic [CNT_W-1:0] borrow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_q <= '0;
    end else if (push && !bus.final_carry && (borrow_q != '1)) begin
      borrow_q <= borrow_q + 1'b1;
    end
  end

  assign bus.borrow_cnt = borrow_q;
`else
  assign bus.borrow_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sub_result_fifo.sv
// Directed plus randomized bench for sub_result_fifo against a queue model of
// A-B results; borrow expectations follow SUB_FIFO_STATS_EN.
module tb_sub_result_fifo;
  import sub_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int BORROW_MAX = (1 << CNT_W) - 1;
`ifdef SUB_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  sub_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int model_q[$];
  int model_borrow = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive A-B as the subtractor would present it, then check the model.
  task automatic cycle(input bit r, input bit iv, input int a, input int b, input bit ordy);
    int d;
    bit push, pop;
    logic [4:0] od, ed;
    d = a - b;
    rst              = r;
    bus.in_valid     = iv;
    bus.s            = 4'(d);
    bus.final_carry  = (a >= b);
    bus.out_ready    = ordy;
    #1;
    if (!r) begin
      check("in_ready_pre", bus.in_ready, model_q.size() != DEPTH);
      check("out_valid_pre", bus.out_valid, model_q.size() != 0);
    end
    push = iv && (model_q.size() != DEPTH);
    pop  = ordy && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete();
      model_borrow = 0;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (push) begin
        model_q.push_back(d);
        if (a < b && model_borrow < BORROW_MAX) model_borrow++;
      end
    end
    check("count", bus.count, model_q.size());
    check("out_valid", bus.out_valid, model_q.size() != 0);
    check("in_ready", bus.in_ready, model_q.size() != DEPTH);
    check("borrow_cnt", bus.borrow_cnt, STATS ? model_borrow : 0);
    if (model_q.size() != 0) begin
      od = bus.out_diff;
      ed = 5'(model_q[0]);
      check("out_diff", od, ed);
      check("out_neg", bus.out_neg, model_q[0] < 0);
    end
  endtask

  initial begin
    int a, b;
    logic [4:0] od;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.s = '0;
    bus.final_carry = 1'b1;
    bus.out_ready = 1'b0;

    // Reset for two cycles
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    od = bus.out_diff;
    check("diff_after_reset", od, 5'd0);
    check("neg_after_reset", bus.out_neg, 1'b0);

    // Basic pushes and signed conversion
    cycle(0, 1, 10, 10, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 6, 3, 0);
    cycle(0, 1, 3, 6, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Fill, ignored 5th push, drain in order
    cycle(0, 1, 9, 2, 0);
    cycle(0, 1, 1, 14, 0);
    cycle(0, 1, 15, 0, 0);
    cycle(0, 1, 0, 15, 0);
    cycle(0, 1, 7, 7, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);

    // Push and pop together at FULL, then streaming at count 2
    for (int i = 0; i < 4; i++) cycle(0, 1, i, 3 - i, 0);
    cycle(0, 1, 5, 8, 1);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(15, 0);
      b = $urandom_range(15, 0);
      cycle(0, 1, a, b, 1);
    end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Reset mid-operation, concurrent with a push
    cycle(0, 1, 4, 11, 0);
    cycle(0, 1, 12, 1, 0);
    cycle(1, 1, 2, 9, 0);
    cycle(0, 0, 0, 0, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(15, 0);
      b = $urandom_range(15, 0);
      cycle($urandom_range(49, 0) == 0, $urandom_range(1, 0) == 1, a, b, $urandom_range(2, 0) != 0);
    end

    // Borrow counter saturation while draining
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(14, 0);
      b = $urandom_range(15, a + 1);
      cycle(0, 1, a, b, 1);
    end
    check("borrow_saturated", bus.borrow_cnt, STATS ? BORROW_MAX : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
